// File: rtl/ela_pkg.sv
// Shared types and sizing helpers for the ELA frame sequencer.
package ela_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_LOAD,
      S_EMIT_INT,
      S_EMIT_CPY,
      S_DONE
   } ela_state_e;

   localparam logic OUT_COPY   = 1'b0;
   localparam logic OUT_INTERP = 1'b1;

   localparam int unsigned DEF_WIDTH   = 16;
   localparam int unsigned DEF_IN_ROWS = 5;

   function automatic int unsigned out_rows(input int unsigned in_rows);
      return 2 * in_rows - 1;
   endfunction

   function automatic int unsigned col_width(input int unsigned width);
      return $clog2(width);
   endfunction

   function automatic int unsigned row_idx_width(input int unsigned in_rows);
      return $clog2(2 * in_rows);
   endfunction

   localparam int unsigned DEF_OUT_ROWS = out_rows(DEF_IN_ROWS);

endpackage

// File: rtl/ela_col_cnt.sv
// WIDTH-modulo column counter shared by the load and emit passes.
module ela_col_cnt
#(
   parameter int unsigned WIDTH = 16,
   localparam int unsigned CW   = $clog2(WIDTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   output logic [CW-1:0] cnt_o,
   output logic          tc_o
);

   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tc_o  = en_i && (cnt_q == CNT_MAX);
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ela_frame_ctrl.sv
// Frame sequencer for the ELA datapath: row requests, ping-pong buffer
// steering and copy/interpolate pass scheduling.
module ela_frame_ctrl
   import ela_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned IN_ROWS = DEF_IN_ROWS
) (
   input  logic                                clk,
   input  logic                                rst,
   output logic                                req,
   output logic                                buf_we,
   output logic                                wr_buf,
   output logic [$clog2(WIDTH)-1:0]            wr_addr,
   output logic [$clog2(WIDTH)-1:0]            rd_addr,
   output logic                                up_buf,
   output logic                                out_sel,
   output logic                                col_first,
   output logic                                col_last,
   output logic                                valid,
   output logic [$clog2(2*IN_ROWS)-1:0]        row_idx,
   output logic                                done
);

   localparam int unsigned COL_W  = col_width(WIDTH);
   localparam int unsigned IN_W   = $clog2(IN_ROWS);
   localparam int unsigned RIDX_W = row_idx_width(IN_ROWS);

   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(WIDTH - 1);
   localparam logic [IN_W-1:0]   LAST_IN  = IN_W'(IN_ROWS - 1);
   localparam logic [RIDX_W-1:0] LAST_OUT = RIDX_W'(out_rows(IN_ROWS) - 1);

   ela_state_e        state_q, state_d;
   logic [IN_W-1:0]   in_row_q, in_row_d;
   logic [RIDX_W-1:0] row_idx_q, row_idx_d;
   logic [COL_W-1:0]  col;
   logic              col_tc;
   logic              col_en;

   ela_col_cnt #(.WIDTH(WIDTH)) u_col_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (col_en),
      .cnt_o  (col),
      .tc_o   (col_tc)
   );

   always_comb begin
      state_d   = state_q;
      in_row_d  = in_row_q;
      row_idx_d = row_idx_q;
      col_en    = 1'b0;
      req       = 1'b0;
      buf_we    = 1'b0;
      wr_buf    = 1'b0;
      wr_addr   = '0;
      rd_addr   = '0;
      up_buf    = 1'b0;
      out_sel   = OUT_COPY;
      col_first = 1'b0;
      col_last  = 1'b0;
      valid     = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            req     = 1'b1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            col_en  = 1'b1;
            buf_we  = 1'b1;
            wr_buf  = in_row_q[0];
            wr_addr = col;
            // Row 0 has no upper neighbour, so it goes straight to a copy pass.
            if (col_tc) state_d = (in_row_q == '0) ? S_EMIT_CPY : S_EMIT_INT;
         end
         S_EMIT_INT, S_EMIT_CPY: begin
            col_en    = 1'b1;
            valid     = 1'b1;
            rd_addr   = col;
            col_first = (col == '0);
            col_last  = (col == COL_MAX);
            if (state_q == S_EMIT_INT) begin
               out_sel = OUT_INTERP;
               up_buf  = ~in_row_q[0];
            end else begin
               up_buf  = in_row_q[0];
            end
            if (col_tc) begin
               if (row_idx_q != LAST_OUT) row_idx_d = row_idx_q + 1'b1;
               if (state_q == S_EMIT_INT) begin
                  state_d = S_EMIT_CPY;
               end else if (in_row_q == LAST_IN) begin
                  state_d = S_DONE;
               end else begin
                  in_row_d = in_row_q + 1'b1;
                  state_d  = S_REQ;
               end
            end
         end
         S_DONE: done = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         in_row_q  <= '0;
         row_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         in_row_q  <= in_row_d;
         row_idx_q <= row_idx_d;
      end
   end

   assign row_idx = row_idx_q;

endmodule
